gate_tt_checker: RTL

- Self-checking sequencer for any 2-input basic gate (NOR, NAND, AND, OR, XOR, XNOR) instantiated beside it.
- On start, drives the gate inputs through all four combinations 00, 01, 10, 11, waits a settle interval per vector and samples the gate output.
- Compares each sample against an expected 4-bit truth table and reports a per-vector fail mask plus a pass flag.
- Replaces hand-written truth-table benches with one reusable on-chip/bench controller.

---
 rtl/gate_tt_pkg.sv | 23 ++
 rtl/tt_settle_timer.sv | 40 ++++
 rtl/gate_tt_checker.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/gate_tt_pkg.sv
// Shared types and constants for the 2-input gate truth-table checker.
package gate_tt_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Number of input vectors in a 2-input sweep
    localparam int unsigned NUM_VEC = 4;

    // Expected truth tables; bit index = {a,b}
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-interval counter: clear, load and count-enable, with a terminal-count flag
// that fires on the last settle cycle (or permanently when no settling is needed).
module tt_settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    // Count value seen during the final settle cycle
    localparam logic [CNT_W-1:0] LAST =
        (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    // Counter register: clear has priority over load, load over increment
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Terminal count; constant high when the settle phase is skipped
    always_comb begin
        tc = (SETTLE_CYCLES == 0) ? 1'b1 : (count_q == LAST);
    end

endmodule

// File: rtl/gate_tt_checker.sv
// Truth-table sweep controller: walks {a,b} through 00..11, holds each vector for a
// settle interval, samples the gate output and accumulates a per-vector fail mask.
module gate_tt_checker
    import gate_tt_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] exp_tt,
    input  logic       y_in,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       result_valid,
    output logic [3:0] fail_mask,
    output logic       pass
);

    localparam logic [1:0] LAST_IDX    = 2'(NUM_VEC - 1);
    localparam bit         SKIP_SETTLE = (SETTLE_CYCLES == 0);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] exp_q, exp_d;
    logic [3:0] mask_q, mask_d;
    logic       rv_q, rv_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       tmr_clear;
    logic       tmr_en;
    logic       tmr_tc;

    tt_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (tmr_clear),
        .load     (1'b0),
        .load_val ({CNT_W{1'b0}}),
        .en       (tmr_en),
        .tc       (tmr_tc)
    );

    // Next-state logic for the sweep FSM, vector index, latched table and results
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        exp_d     = exp_q;
        mask_d    = mask_q;
        rv_d      = rv_q;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d     = exp_tt;
                    mask_d    = '0;
                    rv_d      = 1'b0;
                    idx_d     = '0;
                    tmr_clear = 1'b1;
                    if (SKIP_SETTLE) begin
                        state_d = SAMPLE;
                    end else begin
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (y_in != exp_q[idx_q]) begin
                    mask_d[idx_q] = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    rv_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d     = idx_q + 2'd1;
                    tmr_clear = 1'b1;
                    if (SKIP_SETTLE) begin
                        state_d = SAMPLE;
                    end else begin
                        state_d = SETTLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Gate inputs follow the index while a sweep is active, including the DONE cycle
        if (state_d == IDLE) begin
            a_d = 1'b0;
            b_d = 1'b0;
        end else begin
            a_d = idx_d[1];
            b_d = idx_d[0];
        end
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            exp_q   <= '0;
            mask_q  <= '0;
            rv_q    <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            exp_q   <= exp_d;
            mask_q  <= mask_d;
            rv_q    <= rv_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Output decode
    always_comb begin
        a            = a_q;
        b            = b_q;
        busy         = (state_q != IDLE);
        done         = (state_q == DONE);
        result_valid = rv_q;
        fail_mask    = mask_q;
        pass         = rv_q & (mask_q == 4'b0000);
    end

endmodule
